// File: rtl/round_robin_arbiter.sv
// Round-robin / fixed-priority arbiter that holds each grant until the owner's last beat.
// On a last beat it re-arbitrates in the same cycle, so back-to-back grants have no bubble cycle.
module round_robin_arbiter #(
    parameter int WIDTH = 32,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_mod,
    input  logic [WIDTH_LOG-1:0] cfg_pri,
    input  logic [WIDTH-1:0]     req,
    output logic [WIDTH-1:0]     gnt,
    output logic [WIDTH_LOG-1:0] gnt_idx,
    output logic                 gnt_vld,
    input  logic                 gnt_rdy,
    input  logic                 gnt_lst,
    output logic [WIDTH_LOG-1:0] ptr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]           state_q,   state_d;
    logic [WIDTH-1:0]     gnt_q,     gnt_d;
    logic [WIDTH_LOG-1:0] gnt_idx_q, gnt_idx_d;
    logic                 gnt_vld_q, gnt_vld_d;
    logic [WIDTH_LOG-1:0] ptr_q,     ptr_d;

    logic                 last_beat;
    logic [WIDTH_LOG-1:0] next_ptr;
    logic [WIDTH_LOG-1:0] search_start;
    logic                 win_found;
    logic [WIDTH_LOG-1:0] win_idx;
    logic [WIDTH-1:0]     win_onehot;

    assign last_beat = (state_q == BUSY) && gnt_vld_q && gnt_rdy && gnt_lst;
    assign next_ptr  = gnt_idx_q + WIDTH_LOG'(1);

    // On a last beat the new pointer is not yet registered, so search from gnt_idx+1 directly.
    always_comb begin
        if (cfg_mod) begin
            search_start = cfg_pri;
        end else if (state_q == BUSY) begin
            search_start = next_ptr;
        end else begin
            search_start = ptr_q;
        end
    end

    always_comb begin
        logic [WIDTH_LOG-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cand = search_start + WIDTH_LOG'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                if (win_found) begin
                    state_d   = BUSY;
                    gnt_d     = win_onehot;
                    gnt_idx_d = win_idx;
                    gnt_vld_d = 1'b1;
                end
            end
            BUSY: begin
                if (last_beat) begin
                    ptr_d = next_ptr;
                    if (win_found) begin
                        gnt_d     = win_onehot;
                        gnt_idx_d = win_idx;
                        gnt_vld_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        gnt_vld_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign ptr     = ptr_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter at WIDTH=4: directed vector table, reset sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_round_robin_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cfg_mod = 1'b0;
    logic [1:0]   cfg_pri = '0;
    logic [W-1:0] req = '0;
    logic [W-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_vld;
    logic         gnt_rdy = 1'b0;
    logic         gnt_lst = 1'b0;
    logic [1:0]   ptr;

    int n_checks = 0;
    int n_pass   = 0;

    round_robin_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_mod (cfg_mod),
        .cfg_pri (cfg_pri),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .gnt_rdy (gnt_rdy),
        .gnt_lst (gnt_lst),
        .ptr     (ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mod;
        logic [1:0] pri;
        logic [3:0] rq;
        logic       rdy;
        logic       lst;
        logic [3:0] e_gnt;
        logic [1:0] e_idx;
        logic       e_vld;
        logic [1:0] e_ptr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic m, logic [1:0] p, logic [3:0] r, logic rd, logic ls,
                                logic [3:0] eg, logic [1:0] ei, logic ev, logic [1:0] ep);
        vec_t v;
        v.mod = m; v.pri = p; v.rq = r; v.rdy = rd; v.lst = ls;
        v.e_gnt = eg; v.e_idx = ei; v.e_vld = ev; v.e_ptr = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                             input logic ev, input logic [1:0] ep);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(ei));
        chk({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(ev));
        chk({tag, ".ptr"}, 32'(ptr), 32'(ep));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant must be one-hot or zero, and agree with gnt_idx/gnt_vld, on every cycle.
    always @(negedge clk) begin
        n_checks++;
        if ($onehot0(gnt) && (gnt_vld == (gnt != '0)) && (!gnt_vld || gnt == (4'b0001 << gnt_idx)))
            n_pass++;
        else
            $display("FAIL onehot: gnt=%b gnt_idx=%0d gnt_vld=%b", gnt, gnt_idx, gnt_vld);
    end

    // Reference model: who owns the resource, and where round-robin search begins.
    int m_busy, m_owner, m_ptr;

    function automatic int pick(int start, logic [3:0] r);
        for (int k = 0; k < W; k++) begin
            if (r[(start + k) % W]) return (start + k) % W;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic m, input logic [1:0] p, input logic [3:0] r,
                              input logic rd, input logic ls);
        int w;
        if (m_busy == 0) begin
            if (r != 0) begin
                m_owner = pick(m ? int'(p) : m_ptr, r);
                m_busy  = 1;
            end
        end else if (rd && ls) begin
            m_ptr = (m_owner + 1) % W;
            w = pick(m ? int'(p) : m_ptr, r);
            if (w >= 0) m_owner = w;
            else m_busy = 0;
        end
    endtask

    initial begin
        // Reset held with all requesting: nothing granted.
        req = 4'b1111;
        #2 rst_n = 1'b0;
        #1 check_all("rst_async", 4'b0000, 2'd0, 1'b0, 2'd0);
        step();
        check_all("rst_held", 4'b0000, 2'd0, 1'b0, 2'd0);
        rst_n = 1'b1;

        vecs.push_back(mk(0, 0, 4'b1111, 0, 0, 4'b0001, 0, 1, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 1, 1, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 0, 4'b1111, 1, 1, 4'b0100, 2, 1, 2));
        vecs.push_back(mk(0, 0, 4'b1111, 1, 1, 4'b1000, 3, 1, 3));
        vecs.push_back(mk(0, 0, 4'b1111, 1, 1, 4'b0001, 0, 1, 0));
        vecs.push_back(mk(0, 0, 4'b0011, 1, 1, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 0, 4'b0011, 1, 0, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 0, 4'b0011, 0, 1, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 0, 4'b0011, 1, 0, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 0, 4'b0001, 0, 0, 4'b0010, 1, 1, 1));
        vecs.push_back(mk(0, 0, 4'b0011, 1, 1, 4'b0001, 0, 1, 2));
        vecs.push_back(mk(1, 2, 4'b1011, 1, 1, 4'b1000, 3, 1, 1));
        vecs.push_back(mk(1, 2, 4'b1011, 1, 1, 4'b1000, 3, 1, 0));
        vecs.push_back(mk(1, 2, 4'b0011, 1, 1, 4'b0001, 0, 1, 0));
        vecs.push_back(mk(0, 0, 4'b1111, 1, 0, 4'b0001, 0, 1, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 1, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 1, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 4'b0100, 0, 0, 4'b0100, 2, 1, 1));
        vecs.push_back(mk(0, 0, 4'b0100, 1, 1, 4'b0100, 2, 1, 3));

        foreach (vecs[i]) begin
            cfg_mod = vecs[i].mod;
            cfg_pri = vecs[i].pri;
            req     = vecs[i].rq;
            gnt_rdy = vecs[i].rdy;
            gnt_lst = vecs[i].lst;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_idx, vecs[i].e_vld, vecs[i].e_ptr);
        end

        // Reset pulse while busy drops the grant without a clock edge.
        req = 4'b1111; gnt_rdy = 1'b0; gnt_lst = 1'b0; cfg_mod = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all("rst_mid", 4'b0000, 2'd0, 1'b0, 2'd0);
        #1 rst_n = 1'b1;
        step();
        check_all("rst_rel", 4'b0001, 2'd0, 1'b1, 2'd0);

        // Randomized traffic from a clean reset against the reference model.
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_busy = 0; m_owner = 0; m_ptr = 0;
        for (int c = 0; c < 2000; c++) begin
            cfg_mod = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) cfg_pri = 2'($urandom_range(0, 3));
            req     = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            gnt_rdy = 1'($urandom_range(0, 1));
            gnt_lst = 1'($urandom_range(0, 1));
            model_edge(cfg_mod, cfg_pri, req, gnt_rdy, gnt_lst);
            step();
            check_all($sformatf("rnd%0d", c),
                      m_busy != 0 ? (4'b0001 << m_owner) : 4'b0000,
                      2'(m_owner), 1'(m_busy), 2'(m_ptr));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the number of requesters; legal values are powers of two, 2 or greater.
REQ-002 The block SHALL have localparam WIDTH_LOG = $clog2(WIDTH), meaning the width of the index and pointer.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with the clock and reset ports named clk and rst_n.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cfg_mod, input, 1, arbitration mode: 0 = round-robin, 1 = fixed priority.
- cfg_pri, input, WIDTH_LOG, highest-priority index in fixed mode.
- req, input, WIDTH, per-requester request.
- gnt, output, WIDTH, one-hot grant, registered.
- gnt_idx, output, WIDTH_LOG, binary index of the granted requester, registered.
- gnt_vld, output, 1, a grant is active (resource owned).
- gnt_rdy, input, 1, the resource accepts a beat this cycle.
- gnt_lst, input, 1, qualifies an accepted beat as the last beat of the transfer.
- ptr, output, WIDTH_LOG, current round-robin priority pointer (debug).

Function
REQ-005 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (gnt_vld=1).
REQ-006 The effective priority SHALL be eff_pri = cfg_pri when cfg_mod=1, else ptr.
REQ-007 The winner search SHALL start at index eff_pri and ascend modulo WIDTH; the winner is the first index with req set.
REQ-008 In IDLE, when req is nonzero, the next edge SHALL load gnt/gnt_idx with the winner, set gnt_vld=1 and enter BUSY; latency from req sampled to grant visible is 1 cycle.
REQ-009 In IDLE, when req is all zero, all outputs SHALL hold their values with gnt=0 and gnt_vld=0.
REQ-010 A beat SHALL be defined as gnt_vld and gnt_rdy both high at a rising edge.
REQ-011 In BUSY, gnt and gnt_idx SHALL stay stable until a beat with gnt_lst=1.
- req changes, cfg changes and non-last beats have no effect on them.
REQ-012 Deassertion of req by the owner before its last beat is a protocol violation, and the block SHALL keep the grant anyway.
REQ-013 On a last beat, ptr SHALL update to (gnt_idx+1) mod WIDTH, wrapping from WIDTH-1 to 0.
- This update happens in both modes.
REQ-014 On a last beat, the block SHALL re-arbitrate in the same cycle with no bubble cycle.
- Search start is (gnt_idx+1) mod WIDTH in round-robin mode, or cfg_pri in fixed mode.
- It uses the req sampled in that cycle, so the previous owner has lowest priority in round-robin.
- If a winner exists, the block stays in BUSY with the new grant.
- If req is all zero, the block enters IDLE with gnt=0 and gnt_vld=0.
REQ-015 gnt_lst without gnt_rdy, or with gnt_vld=0, SHALL be ignored.
REQ-016 gnt SHALL be one-hot or zero at all times, and gnt_idx SHALL equal the index of the set bit whenever gnt_vld=1.
REQ-017 A change of cfg_mod or cfg_pri SHALL take effect only at the next arbitration point (IDLE with req nonzero, or a last beat).

Reset
REQ-018 While rst_n=0, the block SHALL asynchronously force state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0 and ptr=0.
REQ-019 On reset asserted mid-transfer, the block SHALL drop the grant immediately, with no completion of the transfer.
REQ-020 After reset release, the first grant SHALL occur no earlier than the first edge with rst_n=1 and req nonzero.

Verification (WIDTH=4)
REQ-021 Reset/idle: rst_n=0 with req=4'b1111 -> gnt=0, gnt_vld=0, ptr=0; after release, 1 cycle later gnt=4'b0001, gnt_idx=0.
REQ-022 Round-robin rotation: req=4'b1111 held, every beat gnt_lst=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001, with one grant per cycle and no bubbles; ptr wraps from 3 to 0.
REQ-023 Multi-beat hold: owner idx 1 with req=4'b0011 and beats gnt_lst=0,0,1 (gnt_rdy toggling) -> gnt=0010 stable until the last beat, then 0001 on the next edge and ptr=2.
REQ-024 Fixed mode: cfg_mod=1, cfg_pri=2, req=4'b1011 -> winner idx 3; after the last beat with req unchanged -> idx 3 again; after setting req=4'b0011 -> idx 0.
REQ-025 Drain to idle: last beat with req=0 -> next cycle gnt_vld=0 and state IDLE; req=4'b0100 then gives gnt=0100 one cycle later.
REQ-026 Reset mid-transfer: rst_n pulsed low while BUSY -> gnt=0 within the same cycle and ptr=0 with no clock edge required; a bench assertion checks one-hot gnt every cycle.
